line_rasterizer: RTL and testbench

Active line writer for the sprite/overlay pipeline. It accepts a pair of endpoints on a start strobe and walks the Bresenham path across all eight octants, one pixel at a time. Each pixel goes out as an (x, y, color) beat on a valid/ready stream that feeds the framebuffer write port. It is the producer-side counterpart of the raster-scan line sprites: those test each hcount/vcount against the line, while this block generates the line's pixel coordinates directly for storage.

---
 rtl/line_rasterizer_if.sv | 25 ++
 rtl/line_rasterizer.sv | 177 +++++++++++++++++
 tb/tb_line_rasterizer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/line_rasterizer_if.sv
// Pixel beat stream from the line rasterizer to the framebuffer write port.
// The producer drives the beat; the sink answers with ready.
interface line_rasterizer_if;
    logic        pixel_valid_out;
    logic        pixel_ready_in;
    logic [10:0] pixel_x_out;
    logic [9:0]  pixel_y_out;
    logic [23:0] pixel_color_out;

    modport master (
        output pixel_valid_out,
        output pixel_x_out,
        output pixel_y_out,
        output pixel_color_out,
        input  pixel_ready_in
    );

    modport slave (
        input  pixel_valid_out,
        input  pixel_x_out,
        input  pixel_y_out,
        input  pixel_color_out,
        output pixel_ready_in
    );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line writer: walks all eight octants and emits one
// (x, y, color) beat per accepted handshake.
module line_rasterizer #(
    parameter logic [23:0] COLOR = 24'hFF_FF_FF
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic [10:0]               x1_in,
    input  logic [10:0]               x2_in,
    input  logic [9:0]                y1_in,
    input  logic [9:0]                y2_in,
    output logic                      busy_out,
    output logic                      done_out,
    line_rasterizer_if.master         pix
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [10:0]        x1_q;
    logic [10:0]        x2_q;
    logic [9:0]         y1_q;
    logic [9:0]         y2_q;
    logic [10:0]        cur_x_q;
    logic [9:0]         cur_y_q;
    logic signed [13:0] dx_q;
    logic signed [13:0] dy_q;
    logic signed [13:0] err_q;
    logic               sx_neg_q;
    logic               sy_neg_q;

    logic               valid_q;
    logic [23:0]        color_q;

    logic               hs;
    logic               at_end;

    logic signed [13:0] x1_e;
    logic signed [13:0] x2_e;
    logic signed [13:0] y1_e;
    logic signed [13:0] y2_e;
    logic signed [13:0] dx_c;
    logic signed [13:0] ady_c;
    logic signed [13:0] dy_c;

    logic signed [13:0] e2;
    logic               step_x;
    logic               step_y;
    logic signed [13:0] err_step;
    logic [10:0]        nx;
    logic [9:0]         ny;

    assign hs     = valid_q & pix.pixel_ready_in;
    assign at_end = (cur_x_q == x2_q) && (cur_y_q == y2_q);

    assign pix.pixel_valid_out = valid_q;
    assign pix.pixel_x_out     = cur_x_q;
    assign pix.pixel_y_out     = cur_y_q;
    assign pix.pixel_color_out = color_q;

    // Endpoint deltas, evaluated from the latched endpoints in SETUP
    always_comb begin
        x1_e  = {3'b000, x1_q};
        x2_e  = {3'b000, x2_q};
        y1_e  = {4'b0000, y1_q};
        y2_e  = {4'b0000, y2_q};
        dx_c  = (x2_q >= x1_q) ? (x2_e - x1_e) : (x1_e - x2_e);
        ady_c = (y2_q >= y1_q) ? (y2_e - y1_e) : (y1_e - y2_e);
        dy_c  = -ady_c;
    end

    // One Bresenham step; x and y may both advance on a diagonal
    always_comb begin
        e2       = err_q <<< 1;
        step_x   = (e2 >= dy_q);
        step_y   = (e2 <= dx_q);
        err_step = err_q
                 + (step_x ? dy_q : 14'sd0)
                 + (step_y ? dx_q : 14'sd0);
        nx       = cur_x_q;
        ny       = cur_y_q;
        if (step_x) begin
            nx = sx_neg_q ? (cur_x_q - 11'd1) : (cur_x_q + 11'd1);
        end
        if (step_y) begin
            ny = sy_neg_q ? (cur_y_q - 10'd1) : (cur_y_q + 10'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_in) state_d = SETUP;
            SETUP:   state_d = DRAW;
            DRAW:    if (hs && at_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status and beat qualifiers are registered from the next state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_out <= 1'b0;
            done_out <= 1'b0;
            valid_q  <= 1'b0;
            color_q  <= '0;
        end else begin
            busy_out <= (state_d != IDLE);
            done_out <= (state_d == DONE);
            valid_q  <= (state_d == DRAW);
            color_q  <= (state_d == DRAW) ? COLOR : 24'h0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x1_q     <= '0;
            x2_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_in) begin
                        x1_q <= x1_in;
                        x2_q <= x2_in;
                        y1_q <= y1_in;
                        y2_q <= y2_in;
                    end
                end
                SETUP: begin
                    dx_q     <= dx_c;
                    dy_q     <= dy_c;
                    err_q    <= dx_c + dy_c;
                    sx_neg_q <= (x2_q < x1_q);
                    sy_neg_q <= (y2_q < y1_q);
                    cur_x_q  <= x1_q;
                    cur_y_q  <= y1_q;
                end
                DRAW: begin
                    if (hs && !at_end) begin
                        err_q   <= err_step;
                        cur_x_q <= nx;
                        cur_y_q <= ny;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: fixed lines with hand-derived
// Bresenham beats, backpressure, ignored restart and async reset.
module tb_line_rasterizer;

    logic        clk_in;
    logic        rst_n_in;
    logic        start_in;
    logic [10:0] x1_in;
    logic [10:0] x2_in;
    logic [9:0]  y1_in;
    logic [9:0]  y2_in;
    logic        busy_out;
    logic        done_out;

    line_rasterizer_if pix();

    line_rasterizer #(.COLOR(24'hFF_FF_FF)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (start_in),
        .x1_in    (x1_in),
        .x2_in    (x2_in),
        .y1_in    (y1_in),
        .y2_in    (y2_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .pix      (pix.master)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int vectors;
    int miscompares;
    int qx[$];
    int qy[$];

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; the start is accepted at the next posedge.
    task automatic run_line(input logic [10:0] ax1, input logic [9:0] ay1,
                            input logic [10:0] ax2, input logic [9:0] ay2,
                            input int stall_at, input int stall_len,
                            input int restart_at);
        x1_in = ax1; y1_in = ay1; x2_in = ax2; y2_in = ay2;
        pix.pixel_ready_in = 1'b1;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check("setup_busy", 32'(busy_out), 32'd1);
        check("setup_valid", 32'(pix.pixel_valid_out), 32'd0);
        for (int i = 0; i < qx.size(); i++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            check($sformatf("b%0d_valid", i), 32'(pix.pixel_valid_out), 32'd1);
            check($sformatf("b%0d_x", i), 32'(pix.pixel_x_out), 32'(qx[i]));
            check($sformatf("b%0d_y", i), 32'(pix.pixel_y_out), 32'(qy[i]));
            check($sformatf("b%0d_col", i), 32'(pix.pixel_color_out),
                  32'h00FF_FFFF);
            check($sformatf("b%0d_busy", i), 32'(busy_out), 32'd1);
            check($sformatf("b%0d_done", i), 32'(done_out), 32'd0);
            if (i == restart_at) begin
                x1_in = 11'd50; y1_in = 10'd60;
                x2_in = 11'd70; y2_in = 10'd80;
                start_in = 1'b1;
            end
            if (i == stall_at) begin
                pix.pixel_ready_in = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk_in);
                    check($sformatf("st%0d_valid", s),
                          32'(pix.pixel_valid_out), 32'd1);
                    check($sformatf("st%0d_x", s),
                          32'(pix.pixel_x_out), 32'(qx[i]));
                    check($sformatf("st%0d_y", s),
                          32'(pix.pixel_y_out), 32'(qy[i]));
                end
                pix.pixel_ready_in = 1'b1;
            end
        end
        @(negedge clk_in);
        check("done_pulse", 32'(done_out), 32'd1);
        check("done_busy", 32'(busy_out), 32'd1);
        check("done_valid", 32'(pix.pixel_valid_out), 32'd0);
        check("done_color", 32'(pix.pixel_color_out), 32'd0);
        @(negedge clk_in);
        check("idle_done", 32'(done_out), 32'd0);
        check("idle_busy", 32'(busy_out), 32'd0);
        check("idle_valid", 32'(pix.pixel_valid_out), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n_in = 1'b0;
        start_in = 1'b0;
        x1_in = '0; x2_in = '0; y1_in = '0; y2_in = '0;
        pix.pixel_ready_in = 1'b1;
        #2;
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_valid", 32'(pix.pixel_valid_out), 32'd0);
        check("rst_x", 32'(pix.pixel_x_out), 32'd0);
        check("rst_y", 32'(pix.pixel_y_out), 32'd0);
        check("rst_color", 32'(pix.pixel_color_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        qx = '{0, 1, 2, 3, 4};
        qy = '{0, 1, 1, 2, 2};
        run_line(11'd0, 10'd0, 11'd4, 10'd2, -1, 0, -1);

        qx = '{2, 2, 2, 2, 2};
        qy = '{5, 4, 3, 2, 1};
        run_line(11'd2, 10'd5, 11'd2, 10'd1, -1, 0, -1);

        qx = '{7};
        qy = '{9};
        run_line(11'd7, 10'd9, 11'd7, 10'd9, -1, 0, -1);

        qx = '{0, 1, 2, 3};
        qy = '{0, 0, 0, 0};
        run_line(11'd0, 10'd0, 11'd3, 10'd0, 1, 3, -1);

        qx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        qy = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 3, 3};
        run_line(11'd0, 10'd0, 11'd10, 10'd3, -1, 0, 4);

        // Issued in the first idle cycle after done
        qx = '{3, 2, 1, 0};
        qy = '{3, 2, 2, 1};
        run_line(11'd3, 10'd3, 11'd0, 10'd1, -1, 0, -1);

        x1_in = 11'd0; y1_in = 10'd0; x2_in = 11'd10; y2_in = 10'd3;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("pre_rst_valid", 32'(pix.pixel_valid_out), 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst_busy", 32'(busy_out), 32'd0);
        check("arst_done", 32'(done_out), 32'd0);
        check("arst_valid", 32'(pix.pixel_valid_out), 32'd0);
        check("arst_x", 32'(pix.pixel_x_out), 32'd0);
        check("arst_y", 32'(pix.pixel_y_out), 32'd0);
        check("arst_color", 32'(pix.pixel_color_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check($sformatf("post_rst%0d_done", k), 32'(done_out), 32'd0);
            check($sformatf("post_rst%0d_busy", k), 32'(busy_out), 32'd0);
            check($sformatf("post_rst%0d_valid", k),
                  32'(pix.pixel_valid_out), 32'd0);
        end

        qx = '{0, 1};
        qy = '{0, 1};
        run_line(11'd0, 10'd0, 11'd1, 10'd1, -1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
